fetch_pc_sequencer: RTL
=======================

// Module: fetch_pc_sequencer
// PURPOSE
//  Parametrised program-address generator feeding the instruction memory / instruction queue.
//  Issues one address per accepted handshake, accepts branch/flush redirects and halts at program end.
//  Sits between the instruction queue (back-pressure) and the CDB/branch-resolve logic (redirects).
// PARAMETERS
//  ADDR_W      5                   address width in bits
//  STEP        1                   increment per accepted fetch, ADDR_W bits wide
//  RESET_ADDR  0                   address loaded on reset and on start
//  MAX_ADDR    (1<<ADDR_W)-1       last valid program address
// PORTS
//  CLK             in   1        clock; all state updates on negedge CLK
//  CLR_N           in   1        reset, asynchronous, active-low
//  start           in   1        leave IDLE/DONE and begin fetching at RESET_ADDR
//  queue_ready     in   1        instruction queue can accept an address this cycle
//  redirect_valid  in   1        branch/flush redirect request
//  redirect_addr   in   ADDR_W   redirect target
//  addr_out        out  ADDR_W   address presented to instruction memory
//  addr_valid      out  1        addr_out is a fetch request
//  halted          out  1        sequencer is in DONE
//  wrapped         out  1        one-cycle pulse on wrap (PC_WRAP_EN only, else tied 0)
// BEHAVIOUR
//  Reset (CLR_N=0, async): state=IDLE, addr_out=RESET_ADDR, addr_valid=0, halted=0, wrapped=0.
//  States: IDLE, FETCH, REDIRECT, DONE. addr_valid=1 only in FETCH. halted=1 only in DONE.
//  IDLE: start -> FETCH with addr_out=RESET_ADDR. Other inputs ignored.
//  FETCH: accept = addr_valid & queue_ready.
//   - accept, addr_out<MAX_ADDR -> addr_out <= addr_out+STEP (mod 2^ADDR_W), stay FETCH.
//   - accept, addr_out==MAX_ADDR -> see CONFIGURATION.
//   - no accept -> addr_out holds, addr_valid stays 1 (request is stable until taken).
//  Redirect (any state except IDLE): addr_out <= redirect_addr, state -> REDIRECT.
//   - Priority: redirect over accept over start; an accept in the same cycle is dropped.
//   - REDIRECT lasts exactly one cycle with addr_valid=0 (bubble), then FETCH.
//   - A redirect while in REDIRECT reloads the target and restarts the bubble.
//   - redirect_addr>MAX_ADDR -> addr_out loaded, state -> DONE (no fetch issued).
//  DONE: addr_out holds. Exit only via start (-> FETCH at RESET_ADDR) or redirect (-> REDIRECT).
//  Overflow of addr_out+STEP beyond MAX_ADDR while addr_out<MAX_ADDR -> DONE, no wrap.
//  Reset mid-operation: immediate return to reset values. The pending request is lost.
//  Latency: accept on edge N -> new addr_out visible after edge N; redirect -> first valid fetch 2 edges later.
// CONFIGURATION
//  PC_WRAP_EN defined: accept at MAX_ADDR -> addr_out <= RESET_ADDR, stay FETCH, wrapped=1 for one cycle.
//  PC_WRAP_EN undefined: accept at MAX_ADDR -> DONE, addr_valid=0, halted=1; wrapped tied 0.
// STRUCTURE
//  Shared package el_tomasulo_pkg: state enum (IDLE/FETCH/REDIRECT/DONE) and default ADDR_W constant.
//  Single module, with no sub-module. Next-address mux and step adder are inline combinational logic.
// TESTING
//  1. Reset, start, queue_ready=1 continuously -> addr_out 0,1,2,...,31 on successive edges, then halted=1.
//  2. queue_ready=0 for 3 cycles at addr 4 -> addr_out stays 4, addr_valid stays 1. Ready=1 -> 5.
//  3. redirect_valid with addr 20 and queue_ready=1 at addr 7 -> one bubble (addr_valid=0), then 20,21.
//  4. CLR_N low mid-fetch at addr 9 -> addr_out=0, state IDLE immediately, without waiting for a clock edge.
//  5. PC_WRAP_EN: accept at 31 -> addr_out=0, wrapped pulse once. Without the macro -> halted=1 at 31.
//  6. STEP=3, MAX_ADDR=10 -> 0,3,6,9, then DONE. redirect_addr=12 with MAX_ADDR=10 -> DONE, no fetch.

Source files
------------

// File: rtl/el_tomasulo_pkg.sv
// el_tomasulo_pkg: shared sequencer state encoding and default address width
package el_tomasulo_pkg;

    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIRECT,
        DONE
    } state_e;

endpackage

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: program-address generator with back-pressure, redirects and end-of-program halt
// Ports: CLK (state updates on negedge), CLR_N (async active-low reset), start, queue_ready,
//        redirect_valid, redirect_addr -> addr_out, addr_valid (FETCH), halted (DONE), wrapped.
// Build option: define PC_WRAP_EN to wrap from MAX_ADDR back to RESET_ADDR instead of halting.
module fetch_pc_sequencer
    import el_tomasulo_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] STEP       = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] MAX_ADDR   = {ADDR_W{1'b1}}
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              start,
    input  logic              queue_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    output logic              halted,
    output logic              wrapped
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W:0]   sum;

    // One extra bit so a step past MAX_ADDR is detected instead of silently wrapping.
    assign sum = {1'b0, addr_q} + {1'b0, STEP};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wrapped_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = FETCH;
                addr_d  = RESET_ADDR;
            end
        end else if (redirect_valid) begin
            addr_d  = redirect_addr;
            state_d = (redirect_addr > MAX_ADDR) ? DONE : REDIRECT;
        end else if (state_q == REDIRECT) begin
            state_d = FETCH;
        end else if (state_q == FETCH && queue_ready) begin
            if (addr_q == MAX_ADDR) begin
`ifdef PC_WRAP_EN
                addr_d    = RESET_ADDR;
                wrapped_d = 1'b1;
`else
                state_d   = DONE;
`endif
            end else if (sum > {1'b0, MAX_ADDR}) begin
                state_d = DONE;
            end else begin
                addr_d = sum[ADDR_W-1:0];
            end
        end else if (state_q == DONE && start) begin
            state_d = FETCH;
            addr_d  = RESET_ADDR;
        end
    end

    always_ff @(negedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q   <= IDLE;
            addr_q    <= RESET_ADDR;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = (state_q == FETCH);
    assign halted     = (state_q == DONE);
    assign wrapped    = wrapped_q;

endmodule
